// File: rtl/ptp_parser_arb_if.sv
// Packet stream bundle carried from a TSU tap to the parser arbiter.
// Signals: data/valid/sop/eop/mod driven by the source, ready by the sink.
interface ptp_parser_arb_if;
    logic [31:0] data;
    logic        valid;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        ready;

    modport master (
        output data, valid, sop, eop, mod,
        input  ready
    );

    modport slave (
        input  data, valid, sop, eop, mod,
        output ready
    );
endinterface

// File: rtl/ptp_parser_arb.sv
// Packet-granular round-robin arbiter sharing one ptp_parser between two
// 32-bit streams; forwards whole packets on int_* and routes results back.
// Ports: clk, rst (async, active-high); src0/src1 stream slaves; int_* to
// parser; ptp_found/ptp_infor from parser; found/infor per source; busy;
// drop_cnt (saturating count of discarded non-sop beats while idle).
// Option: define ARB_TIMEOUT_EN to abort a granted packet after TIMEOUT
// consecutive idle cycles with a forced eop beat and suppressed result.
module ptp_parser_arb #(
    parameter int TIMEOUT = 64,
    parameter int DROP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ptp_parser_arb_if.slave   src0,
    ptp_parser_arb_if.slave   src1,
    output logic [31:0]       int_data,
    output logic              int_valid,
    output logic              int_sop,
    output logic              int_eop,
    output logic [1:0]        int_mod,
    input  logic              ptp_found,
    input  logic [19:0]       ptp_infor,
    output logic              found0,
    output logic [19:0]       infor0,
    output logic              found1,
    output logic [19:0]       infor1,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [31:0]       int_data_q, int_data_d;
    logic              int_valid_q, int_valid_d;
    logic              int_sop_q, int_sop_d;
    logic              int_eop_q, int_eop_d;
    logic [1:0]        int_mod_q, int_mod_d;
    logic [2:0]        tag_eop_q, tag_eop_d;
    logic [2:0]        tag_src_q, tag_src_d;
    logic [2:0]        tag_abt_q, tag_abt_d;
    logic              found0_q, found0_d;
    logic              found1_q, found1_d;
    logic [19:0]       infor0_q, infor0_d;
    logic [19:0]       infor1_q, infor1_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic [1:0]        drop_inc;
    logic              new_eop, new_src, new_abt;
    logic              rdy0, rdy1, req0, req1, hit;
    logic              sel;
    logic [31:0]       s_data;
    logic              s_valid, s_sop, s_eop;
    logic [1:0]        s_mod;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Beat of whichever source currently owns the grant.
    assign sel     = (state_q == GNT1);
    assign s_data  = sel ? src1.data  : src0.data;
    assign s_valid = sel ? src1.valid : src0.valid;
    assign s_sop   = sel ? src1.sop   : src0.sop;
    assign s_eop   = sel ? src1.eop   : src0.eop;
    assign s_mod   = sel ? src1.mod   : src0.mod;
    assign req0    = src0.valid && src0.sop;
    assign req1    = src1.valid && src1.sop;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        int_data_d  = '0;
        int_valid_d = 1'b0;
        int_sop_d   = 1'b0;
        int_eop_d   = 1'b0;
        int_mod_d   = '0;
        new_eop     = 1'b0;
        new_src     = 1'b0;
        new_abt     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                // sop beats wait for the grant; stray beats are eaten.
                rdy0 = src0.valid && !src0.sop;
                rdy1 = src1.valid && !src1.sop;
                if (req0 && req1) begin
                    state_d = last_q ? GNT0 : GNT1;
                    last_d  = !last_q;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                rdy0 = !sel;
                rdy1 = sel;
                if (s_valid) begin
                    int_data_d  = s_data;
                    int_valid_d = 1'b1;
                    int_sop_d   = s_sop;
                    int_eop_d   = s_eop;
                    int_mod_d   = s_mod;
                    if (s_eop) begin
                        state_d = IDLE;
                        new_eop = 1'b1;
                        new_src = sel;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                if (s_valid) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Close the packet at the parser, result is discarded.
                    int_valid_d = 1'b1;
                    int_eop_d   = 1'b1;
                    new_eop     = 1'b1;
                    new_src     = sel;
                    new_abt     = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        drop_inc = 2'd0;
        if (state_q == IDLE) begin
            drop_inc = {1'b0, rdy0} + {1'b0, rdy1};
        end
        drop_sum = {1'b0, drop_q}
                 + {{(DROP_W - 1){1'b0}}, drop_inc};
        drop_d   = drop_sum[DROP_W] ? '1
                                    : drop_sum[DROP_W-1:0];

        tag_eop_d = {tag_eop_q[1:0], new_eop};
        tag_src_d = {tag_src_q[1:0], new_src};
        tag_abt_d = {tag_abt_q[1:0], new_abt};

        // Oldest tag lines up with the parser's result cycle.
        hit      = ptp_found && tag_eop_q[2] && !tag_abt_q[2];
        found0_d = hit && !tag_src_q[2];
        found1_d = hit && tag_src_q[2];
        infor0_d = found0_d ? ptp_infor : '0;
        infor1_d = found1_d ? ptp_infor : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            int_data_q  <= '0;
            int_valid_q <= 1'b0;
            int_sop_q   <= 1'b0;
            int_eop_q   <= 1'b0;
            int_mod_q   <= '0;
            tag_eop_q   <= '0;
            tag_src_q   <= '0;
            tag_abt_q   <= '0;
            found0_q    <= 1'b0;
            found1_q    <= 1'b0;
            infor0_q    <= '0;
            infor1_q    <= '0;
            drop_q      <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            int_data_q  <= int_data_d;
            int_valid_q <= int_valid_d;
            int_sop_q   <= int_sop_d;
            int_eop_q   <= int_eop_d;
            int_mod_q   <= int_mod_d;
            tag_eop_q   <= tag_eop_d;
            tag_src_q   <= tag_src_d;
            tag_abt_q   <= tag_abt_d;
            found0_q    <= found0_d;
            found1_q    <= found1_d;
            infor0_q    <= infor0_d;
            infor1_q    <= infor1_d;
            drop_q      <= drop_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    // Ready is combinational; hold it low while reset is applied.
    assign src0.ready = rdy0 && !rst;
    assign src1.ready = rdy1 && !rst;
    assign int_data   = int_data_q;
    assign int_valid  = int_valid_q;
    assign int_sop    = int_sop_q;
    assign int_eop    = int_eop_q;
    assign int_mod    = int_mod_q;
    assign found0     = found0_q;
    assign found1     = found1_q;
    assign infor0     = infor0_q;
    assign infor1     = infor1_q;
    assign busy       = (state_q != IDLE);
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ptp_parser_arb.sv
// Directed bench for ptp_parser_arb with a small PTP parser stand-in.
// Run with ARB_TIMEOUT_EN defined to also exercise the abort path.
module tb_ptp_parser_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] int_data;
    logic        int_valid, int_sop, int_eop;
    logic [1:0]  int_mod;
    logic        ptp_found;
    logic [19:0] ptp_infor;
    logic        found0, found1, busy;
    logic [19:0] infor0, infor1;
    logic [2:0]  drop_cnt;

    logic        pf_q = 1'b0;
    logic        rv_q = 1'b0;
    logic        inj_f = 1'b0;
    logic [19:0] pi_q = '0;
    logic [19:0] ri_q = '0;
    logic [31:0] w3 = '0;
    logic [31:0] w11 = '0;
    int          pidx = 0;
    int          sidx;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          l0c[$];
    int          l1c[$];
    logic [19:0] l0i[$];
    logic [19:0] l1i[$];

    always #5 clk = ~clk;

    ptp_parser_arb_if if0 ();
    ptp_parser_arb_if if1 ();

    ptp_parser_arb #(.TIMEOUT(8), .DROP_W(3)) dut (
        .clk(clk), .rst(rst), .src0(if0), .src1(if1),
        .int_data(int_data), .int_valid(int_valid),
        .int_sop(int_sop), .int_eop(int_eop),
        .int_mod(int_mod), .ptp_found(ptp_found),
        .ptp_infor(ptp_infor), .found0(found0),
        .infor0(infor0), .found1(found1),
        .infor1(infor1), .busy(busy), .drop_cnt(drop_cnt)
    );

    assign ptp_found = pf_q | inj_f;
    assign ptp_infor = inj_f ? 20'hABCDE : pi_q;

    // Parser stand-in: ethertype in word 3, seqid in word 11,
    // result two cycles after it sees the eop beat.
    always @(posedge clk) begin
        sidx = int_sop ? 0 : pidx;
        rv_q <= 1'b0;
        if (int_valid) begin
            if (sidx == 3) w3 <= int_data;
            if (sidx == 11) w11 <= int_data;
            pidx <= sidx + 1;
            if (int_eop) begin
                rv_q <= (sidx >= 12)
                     && (w3[31:16] == 16'h88F7);
                ri_q <= {w11[31:16], w3[11:8]};
            end
        end
        pf_q <= rv_q;
        pi_q <= ri_q;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (found0) begin
            l0c.push_back(cyc);
            l0i.push_back(infor0);
        end
        if (found1) begin
            l1c.push_back(cyc);
            l1i.push_back(infor1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic set_src(input int s, input logic v,
                           input logic [31:0] d,
                           input logic sp, input logic ep);
        if (s == 0) begin
            if0.valid = v; if0.data = d;
            if0.sop = sp; if0.eop = ep; if0.mod = 2'd0;
        end else begin
            if1.valid = v; if1.data = d;
            if1.sop = sp; if1.eop = ep; if1.mod = 2'd0;
        end
    endtask

    function automatic logic get_rdy(input int s);
        return (s == 0) ? if0.ready : if1.ready;
    endfunction

    function automatic logic [31:0] pkt_word(
        input int i, input logic [15:0] seq,
        input logic [3:0] msg);
        if (i == 3) return {16'h88F7, 4'h0, msg, 8'h02};
        if (i == 11) return {seq, 16'h0000};
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Sends the first n_send beats of an n-beat packet; last_cyc is
    // the edge count just after the last accepted beat.
    task automatic send_pkt(input int s, input int n,
                            input int n_send,
                            input logic [15:0] seq,
                            input logic [3:0] msg,
                            input int gap_at, input int gap_len,
                            output int last_cyc);
        int t;
        logic r;
        last_cyc = -1;
        for (int i = 0; i < n_send; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    set_src(s, 1'b0, '0, 1'b0, 1'b0);
                end
            end
            @(negedge clk);
            set_src(s, 1'b1, pkt_word(i, seq, msg),
                    i == 0, i == n - 1);
            t = 0;
            forever begin
                #4;
                r = get_rdy(s);
                @(posedge clk);
                #1;
                if (r) break;
                t++;
                if (t >= 200) begin
                    checks++;
                    failures++;
                    $display("FAIL stall src%0d beat %0d ready=0", s, i);
                    set_src(s, 1'b0, '0, 1'b0, 1'b0);
                    return;
                end
                @(negedge clk);
            end
            last_cyc = cyc;
        end
        @(negedge clk);
        set_src(s, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Gathers logged result pulses of source s in cycles lo..hi.
    task automatic find_res(input int s, input int lo, input int hi,
                            output int n, output int c,
                            output logic [19:0] inf);
        while (cyc <= hi) @(negedge clk);
        n = 0; c = -1; inf = '0;
        if (s == 0) begin
            foreach (l0c[k]) if (l0c[k] >= lo && l0c[k] <= hi) begin
                if (n == 0) begin c = l0c[k]; inf = l0i[k]; end
                n++;
            end
        end else begin
            foreach (l1c[k]) if (l1c[k] >= lo && l1c[k] <= hi) begin
                if (n == 0) begin c = l1c[k]; inf = l1i[k]; end
                n++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_src(0, 1'b0, '0, 1'b0, 1'b0);
        set_src(1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        set_src(0, 1'b1, 32'h1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({int_valid, int_sop, int_eop, busy} !== 4'b0) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=0000",
                     {int_valid, int_sop, int_eop, busy});
        end
        checks++;
        if (int_data !== 32'h0 || drop_cnt !== 3'd0) begin
            failures++;
            $display("FAIL rst_regs data=%h drop=%0d exp 0/0",
                     int_data, drop_cnt);
        end
        checks++;
        if ({found0, found1, if0.ready, if1.ready} !== 4'b0) begin
            failures++;
            $display("FAIL rst_out got=%b exp=0000",
                     {found0, found1, if0.ready, if1.ready});
        end
        set_src(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || drop_cnt !== 3'd0) begin
            failures++;
            $display("FAIL rst_release busy=%b drop=%0d exp 0/0",
                     busy, drop_cnt);
        end
    endtask

    task automatic test_single;
        int e, n, c;
        logic [19:0] inf;
        send_pkt(0, 16, 16, 16'h1234, 4'h0, -1, 0, e);
        find_res(0, e + 1, e + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e + 3) begin
            failures++;
            $display("FAIL single_found0 n=%0d cyc=%0d exp n=1 cyc=%0d",
                     n, c, e + 3);
        end
        checks++;
        if (inf !== 20'h12340) begin
            failures++;
            $display("FAIL single_infor0 got=%h exp=12340", inf);
        end
        find_res(1, e + 1, e + 8, n, c, inf);
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL single_found1 got=%0d pulses exp=0", n);
        end
    endtask

    task automatic test_tie;
        int e0, e1, n, c;
        logic [19:0] inf;
        fork
            send_pkt(0, 16, 16, 16'h0A01, 4'h0, -1, 0, e0);
            send_pkt(1, 16, 16, 16'h0B02, 4'h1, -1, 0, e1);
        join
        checks++;
        if (e1 !== e0 + 17) begin
            failures++;
            $display("FAIL tie1_order e0=%0d e1=%0d exp e1=e0+17",
                     e0, e1);
        end
        find_res(0, e0 + 1, e0 + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e0 + 3 || inf !== 20'h0A010) begin
            failures++;
            $display("FAIL tie1_res0 n=%0d cyc=%0d inf=%h exp 1/%0d/0a010",
                     n, c, inf, e0 + 3);
        end
        find_res(1, e1 + 1, e1 + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e1 + 3 || inf !== 20'h0B021) begin
            failures++;
            $display("FAIL tie1_res1 n=%0d cyc=%0d inf=%h exp 1/%0d/0b021",
                     n, c, inf, e1 + 3);
        end
        fork
            send_pkt(0, 16, 16, 16'h0C03, 4'h2, -1, 0, e0);
            send_pkt(1, 16, 16, 16'h0D04, 4'h3, -1, 0, e1);
        join
        checks++;
        if (e0 !== e1 + 17) begin
            failures++;
            $display("FAIL tie2_order e0=%0d e1=%0d exp e0=e1+17",
                     e0, e1);
        end
        find_res(1, e1 + 1, e1 + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e1 + 3 || inf !== 20'h0D043) begin
            failures++;
            $display("FAIL tie2_res1 n=%0d cyc=%0d inf=%h exp 1/%0d/0d043",
                     n, c, inf, e1 + 3);
        end
        find_res(0, e0 + 1, e0 + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e0 + 3 || inf !== 20'h0C032) begin
            failures++;
            $display("FAIL tie2_res0 n=%0d cyc=%0d inf=%h exp 1/%0d/0c032",
                     n, c, inf, e0 + 3);
        end
    endtask

    task automatic test_drop;
        int exp_d[3] = '{5, 7, 7};
        checks++;
        if (drop_cnt !== 3'd0) begin
            failures++;
            $display("FAIL drop_start got=%0d exp=0", drop_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_src(1, 1'b1, 32'h1111_0000 + 32'(k), 1'b0, 1'b0);
            #4;
            checks++;
            if (if1.ready !== 1'b1 || int_valid !== 1'b0) begin
                failures++;
                $display("FAIL drop_beat%0d ready=%b ival=%b exp 1/0",
                         k, if1.ready, int_valid);
            end
            @(posedge clk);
        end
        @(negedge clk);
        set_src(1, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== 3'd3 || int_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_three cnt=%0d ival=%b busy=%b exp 3/0/0",
                     drop_cnt, int_valid, busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_src(0, 1'b1, 32'h2222_0000, 1'b0, 1'b0);
            set_src(1, 1'b1, 32'h3333_0000, 1'b0, 1'b0);
            @(negedge clk);
            set_src(0, 1'b0, '0, 1'b0, 1'b0);
            set_src(1, 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (drop_cnt !== 3'(exp_d[k])) begin
                failures++;
                $display("FAIL drop_dual%0d got=%0d exp=%0d",
                         k, drop_cnt, exp_d[k]);
            end
        end
    endtask

    task automatic test_gaps;
        int e, n, c, nv, ng;
        logic seen;
        logic [19:0] inf;
        nv = 0; ng = 0; seen = 1'b0;
        fork
            send_pkt(0, 16, 16, 16'h5678, 4'h9, 6, 3, e);
            repeat (40) begin
                @(negedge clk);
                if (int_valid) begin
                    nv++;
                    seen = 1'b1;
                end else if (seen && nv < 16) begin
                    ng++;
                end
            end
        join
        checks++;
        if (nv !== 16 || ng !== 3) begin
            failures++;
            $display("FAIL gaps_beats valid=%0d gaps=%0d exp 16/3", nv, ng);
        end
        find_res(0, e + 1, e + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e + 3 || inf !== 20'h56789) begin
            failures++;
            $display("FAIL gaps_res0 n=%0d cyc=%0d inf=%h exp 1/%0d/56789",
                     n, c, inf, e + 3);
        end
    endtask

    task automatic test_stray;
        int lo, n0, n1, c;
        logic [19:0] inf;
        @(negedge clk);
        inj_f = 1'b1;
        lo = cyc;
        @(negedge clk);
        inj_f = 1'b0;
        find_res(0, lo, lo + 6, n0, c, inf);
        find_res(1, lo, lo + 6, n1, c, inf);
        checks++;
        if (n0 !== 0 || n1 !== 0) begin
            failures++;
            $display("FAIL stray_found n0=%0d n1=%0d exp 0/0", n0, n1);
        end
    endtask

    task automatic test_reset_mid;
        int a, e, n, c;
        logic [19:0] inf;
        send_pkt(1, 16, 5, 16'h2222, 4'h0, -1, 0, a);
        checks++;
        if (int_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre ival=%b busy=%b exp 1/1", int_valid, busy);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({int_valid, int_sop, int_eop, busy, if1.ready} !== 5'b0
            || int_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_rst flags=%b data=%h exp 0/0",
                     {int_valid, int_sop, int_eop, busy, if1.ready},
                     int_data);
        end
        @(negedge clk);
        rst = 1'b0;
        find_res(1, a, a + 8, n, c, inf);
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL mid_nores got=%0d pulses exp=0", n);
        end
        send_pkt(1, 16, 16, 16'h3333, 4'h1, -1, 0, e);
        find_res(1, e + 1, e + 8, n, c, inf);
        checks++;
        if (n !== 1 || c !== e + 3 || inf !== 20'h33331) begin
            failures++;
            $display("FAIL mid_next n=%0d cyc=%0d inf=%h exp 1/%0d/33331",
                     n, c, inf, e + 3);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int a, n, c;
        logic [19:0] inf;
        send_pkt(0, 16, 13, 16'h4444, 4'h0, -1, 0, a);
        while (cyc < a + 7) @(negedge clk);
        checks++;
        if (int_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL to_before ival=%b busy=%b exp 0/1",
                     int_valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({int_valid, int_sop, int_eop} !== 3'b101
            || int_data !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_forced vse=%b data=%h busy=%b exp 101/0/0",
                     {int_valid, int_sop, int_eop}, int_data, busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_src(0, 1'b1, 32'h7777_0000, 1'b0, 1'b0);
        end
        @(negedge clk);
        set_src(0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== 3'd3) begin
            failures++;
            $display("FAIL to_drops got=%0d exp=3", drop_cnt);
        end
        find_res(0, a + 8, a + 14, n, c, inf);
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL to_nores got=%0d pulses exp=0", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_drop();
        test_gaps();
        test_stray();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ptp_parser_arb.md
Name: ptp_parser_arb

Overview:
- Packet-granularity round-robin arbiter that shares one ptp_parser instance between two 32-bit packet streams (e.g. RX and TX TSU taps).
- Grants one whole packet (sop..eop) at a time and forwards it on a registered int_* bus to the parser.
- Tags each forwarded packet with its source and routes the parser's ptp_found/ptp_infor pulse back to that source's result outputs.

Parameters:
TIMEOUT, 64, idle cycles inside a granted packet before abort (used only with ARB_TIMEOUT_EN)
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
rst  in  1  reset
src0_data  in  32  source 0 packet word
src0_valid  in  1  source 0 beat valid
src0_sop  in  1  source 0 start of packet
src0_eop  in  1  source 0 end of packet
src0_mod  in  2  source 0 valid-byte modulo on eop beat
src0_ready  out  1  source 0 beat accepted when valid&&ready
src1_data/valid/sop/eop/mod/ready  same widths/directions, source 1
int_data  out  32  to parser
int_valid  out  1  to parser
int_sop  out  1  to parser
int_eop  out  1  to parser
int_mod  out  2  to parser
ptp_found  in  1  parser result pulse
ptp_infor  in  20  parser result {seqid, msgid}
found0  out  1  result pulse for source 0
infor0  out  20  result info for source 0
found1  out  1  result pulse for source 1
infor1  out  20  result info for source 1
busy  out  1  a grant is active
drop_cnt  out  DROP_W  non-sop beats discarded while ungranted, saturating

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- On reset all outputs are 0, the FSM goes to IDLE, the last-served pointer is 1 (so source 0 wins the first tie), and the tag pipe is cleared.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Request x = srcx_valid && srcx_sop.
  - With a single request, go to GNTx.
  - With both requesting, grant the source that is not the last-served one, then update the pointer.
  - Ready is 0 for sop beats; the sop beat is held by the source and accepted in GNTx.
  - A valid non-sop beat from either source is consumed (ready=1 for that beat only) and discarded; drop_cnt increments by 1 per dropped beat, by 2 if both sources drop in the same cycle, and saturates at all-ones.
- GNTx:
  - srcx_ready=1; the other source's ready=0, and its beats are held, not dropped.
  - Each accepted beat is registered onto int_* on the next edge.
  - int_valid is 0 with int_sop and int_eop forced to 0 on cycles with no accepted beat.
  - When the eop beat is accepted, go to IDLE, giving at least one bubble cycle between packets.
  - A second sop before eop is forwarded unchanged; the parser restarts on it.
- busy = (state != IDLE).
- Tag pipe (3 stages) shifts every cycle, carrying {eop_accepted, src_id, abort}.
- Result latency, for an eop accepted at edge N:
  - int_* holds the eop beat after N.
  - Parser output is available after N+2.
  - The routed foundx/inforx are registered and valid for one cycle after N+3.
  - foundx = ptp_found && tag valid && tag src==x && !abort; inforx = ptp_infor on that cycle, otherwise 0.
- ptp_found without a matching tag is ignored.
- Reset mid-packet: int_* drops to 0 immediately; the parser sees no eop; no result is produced.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - In GNTx, a counter of consecutive cycles without an accepted beat runs; any accepted beat clears it.
  - When it reaches TIMEOUT, the arbiter drives one int_valid=1, int_eop=1, int_data=0, int_mod=0 beat, sets abort in the tag so the result is suppressed, and returns to IDLE.
  - Later beats of that packet are dropped and counted as drops.
- Undefined: no counter; a stalled source holds the grant indefinitely.

Test Plan:
- Single src0 packet of 16 beats, PTP L2 sync, seqid 0x1234 -> found0=1, infor0=0x12340 exactly 3 cycles after eop accept; found1 stays 0.
- src0 and src1 both present sop at the same cycle after reset -> src0 granted first, src1 next; a second simultaneous tie grants src1; results route to the matching port.
- src1 sends 3 non-sop beats while idle -> all accepted and discarded, drop_cnt=3, int_valid stays 0.
- src0 granted with valid gaps mid-packet -> int_valid low during the gaps, the packet is intact at the parser, and the result still routes correctly.
- rst asserted mid-packet in GNT1 -> all outputs 0 next cycle, no found1; the next packet is parsed normally.
- ARB_TIMEOUT_EN with TIMEOUT=8: src0 stalls 8 cycles mid-packet -> forced eop beat with data 0, no found0, FSM returns to IDLE, and trailing beats raise drop_cnt.
